// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-ported integer register file.
package regfile_pkg;

  localparam int XLEN   = 64;
  localparam int NREGS  = 32;
  localparam int AW     = $clog2(NREGS);
  localparam int SP_IDX = NREGS - 1;

  typedef logic [XLEN-1:0] xword_t;
  typedef logic [AW-1:0]   raddr_t;

  // True when addr selects the SP/XZR alias slot (top index) of an nregs-entry file.
  function automatic logic is_alias_idx(input int unsigned addr, input int unsigned nregs);
    return addr == nregs - 1;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue,
// cleared by writeback, bulk-cleared by flush. The alias slot is never tracked.
module reg_scoreboard #(
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic [NREGS-1:0] clr_vec,
  input  logic             flush,
  output logic [NREGS-1:0] pending,
  output logic             sb_full
);
  import regfile_pkg::is_alias_idx;

  logic [NREGS-1:0] pend_nxt;

  // Clear, then flush, then set: a new producer always supersedes a same-cycle clear or flush.
  always_comb begin
    pend_nxt = pending & ~clr_vec;
    if (flush) begin
      pend_nxt = '0;
    end
    if (iss_en && !is_alias_idx(32'(iss_addr), NREGS)) begin
      pend_nxt[iss_addr] = 1'b1;
    end
    pend_nxt[NREGS-1] = 1'b0;
  end

  // State register; sb_full is computed from the next-state vector so it tracks pending exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      sb_full <= 1'b0;
    end else begin
      pending <= pend_nxt;
      sb_full <= &pend_nxt[NREGS-2:0];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported integer register file with SP/XZR aliasing on the top index,
// optional same-cycle write->read forwarding and a pending-write scoreboard.
module reg_file_mp #(
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int NRD = 3,
  parameter int NWR = 2,
  parameter int BYPASS = 1,
  parameter logic [XLEN-1:0] SP_RESET = '0,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  input  logic [NRD-1:0]      rd_use_sp,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR-1:0]      wr_sp,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic                sb_full
);

  localparam logic [AW-1:0] SP_A = AW'(NREGS - 1);

  logic [XLEN-1:0]  regs [NREGS];
  logic [AW-1:0]    wa   [NWR];
  logic [XLEN-1:0]  wd   [NWR];
  logic [NWR-1:0]   wr_eff;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] pending;

  // Unpack write ports; a write to the alias slot without wr_sp is an XZR write and is dropped.
  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      wa[j]     = wr_addr[j*AW +: AW];
      wd[j]     = wr_data[j*XLEN +: XLEN];
      wr_eff[j] = wr_en[j] && !((wa[j] == SP_A) && !wr_sp[j]);
    end
  end

  // Registers touched by an effective write this cycle; these retire their pending bit.
  always_comb begin
    clr_vec = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_eff[j]) begin
        clr_vec[wa[j]] = 1'b1;
      end
    end
  end

  // Storage update; ports are visited in ascending order so the highest port wins a collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= (r == NREGS - 1) ? SP_RESET : '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_eff[j]) begin
          regs[wa[j]] <= wd[j];
        end
      end
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .clr_vec  (clr_vec),
    .flush    (flush),
    .pending  (pending),
    .sb_full  (sb_full)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            xzr;
    logic [XLEN-1:0] stored;

    assign ra         = rd_addr[i*AW +: AW];
    assign xzr        = (ra == SP_A) && !rd_use_sp[i];
    assign stored     = xzr ? '0 : regs[ra];
    assign rd_busy[i] = (ra != SP_A) && pending[ra];

    if (BYPASS != 0) begin : g_byp
      logic            hit;
      logic [XLEN-1:0] fwd;

      // Forward the highest-index matching write, consistent with the storage collision rule.
      always_comb begin
        hit = 1'b0;
        fwd = '0;
        for (int j = 0; j < NWR; j++) begin
          if (wr_eff[j] && (wa[j] == ra)) begin
            hit = 1'b1;
            fwd = wd[j];
          end
        end
      end

      assign rd_data[i*XLEN +: XLEN] = (hit && !xzr) ? fwd : stored;
    end else begin : g_nobyp
      assign rd_data[i*XLEN +: XLEN] = stored;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: two register files (forwarding on/off) share stimulus; a
// spec-level model predicts every cycle's outputs and a monitor compares them.
module tb_reg_file_mp;
  import regfile_pkg::xword_t;

  localparam int NRD = 3;
  localparam int NWR = 2;
  localparam int AW  = regfile_pkg::AW;
  localparam int NR  = regfile_pkg::NREGS;
  localparam int SP  = regfile_pkg::SP_IDX;
  localparam xword_t SP_RST = 64'h0123_4567_89ab_cdef;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0] rd_addr;
  logic [NRD-1:0]    rd_use_sp;
  logic [NWR-1:0]    wr_en, wr_sp;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*64-1:0] wr_data;
  logic              iss_en, flush;
  logic [AW-1:0]     iss_addr;
  logic [NRD*64-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]    rd_busy_b, rd_busy_n;
  logic              sb_full_b, sb_full_n;

  int     ra [NRD];
  bit     rsp[NRD];
  bit     wen[NWR];
  bit     wsp[NWR];
  int     wa [NWR];
  xword_t wd [NWR];
  bit     iss;
  int     iaddr;
  bit     fl;

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_addr[i*AW +: AW] = ra[i][AW-1:0];
      rd_use_sp[i]        = rsp[i];
    end
    for (int j = 0; j < NWR; j++) begin
      wr_en[j]              = wen[j];
      wr_sp[j]              = wsp[j];
      wr_addr[j*AW +: AW]   = wa[j][AW-1:0];
      wr_data[j*64 +: 64]   = wd[j];
    end
    iss_en   = iss;
    iss_addr = iaddr[AW-1:0];
    flush    = fl;
  end

  reg_file_mp #(.NRD(NRD), .NWR(NWR), .BYPASS(1), .SP_RESET(SP_RST)) u_dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_use_sp(rd_use_sp),
    .rd_data(rd_data_b), .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_sp(wr_sp),
    .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .sb_full(sb_full_b));

  reg_file_mp #(.NRD(NRD), .NWR(NWR), .BYPASS(0), .SP_RESET(SP_RST)) u_dut_n (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_use_sp(rd_use_sp),
    .rd_data(rd_data_n), .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_sp(wr_sp),
    .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .sb_full(sb_full_n));

  // Reference model state
  xword_t mreg [NR];
  bit     mpend[NR];
  bit     mfull;

  typedef struct packed {
    logic [NRD-1:0][63:0] rdb;
    logic [NRD-1:0][63:0] rdn;
    logic [NRD-1:0]       busy;
    logic                 sbf;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  function automatic bit eff(input int j);
    return wen[j] && !(wa[j] == SP && !wsp[j]);
  endfunction

  function automatic xword_t m_read(input int i, input bit byp);
    if (ra[i] == SP && !rsp[i]) return '0;
    if (byp) begin
      for (int j = NWR - 1; j >= 0; j--) begin
        if (eff(j) && wa[j] == ra[i]) return wd[j];
      end
    end
    return mreg[ra[i]];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      mreg[r]  = '0;
      mpend[r] = 1'b0;
    end
    mreg[SP] = SP_RST;
    mfull    = 1'b0;
  endtask

  task automatic idle();
    for (int i = 0; i < NRD; i++) begin
      ra[i]  = i * 5;
      rsp[i] = 1'b1;
    end
    for (int j = 0; j < NWR; j++) begin
      wen[j] = 1'b0;
      wsp[j] = 1'b0;
      wa[j]  = 0;
      wd[j]  = '0;
    end
    iss   = 1'b0;
    iaddr = 0;
    fl    = 1'b0;
  endtask

  // Record the expected outputs for the inputs now applied, advance the model, pass one edge.
  task automatic step();
    exp_t e;
    bit   done[NR];
    for (int i = 0; i < NRD; i++) begin
      e.rdb[i]  = m_read(i, 1'b1);
      e.rdn[i]  = m_read(i, 1'b0);
      e.busy[i] = (ra[i] == SP) ? 1'b0 : mpend[ra[i]];
    end
    e.sbf = mfull;
    sbq.push_back(e);
    for (int r = 0; r < NR; r++) done[r] = 1'b0;
    for (int j = NWR - 1; j >= 0; j--) begin
      if (eff(j) && !done[wa[j]]) begin
        mreg[wa[j]] = wd[j];
        done[wa[j]] = 1'b1;
      end
    end
    for (int j = 0; j < NWR; j++) if (eff(j)) mpend[wa[j]] = 1'b0;
    if (fl) for (int r = 0; r < NR; r++) mpend[r] = 1'b0;
    if (iss && iaddr != SP) mpend[iaddr] = 1'b1;
    mfull = 1'b1;
    for (int r = 0; r < SP; r++) if (!mpend[r]) mfull = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic int rand_addr();
    case ($urandom_range(0, 5))
      0: return 3;
      1: return 5;
      2: return SP;
      default: return int'($urandom_range(0, SP));
    endcase
  endfunction

  task automatic chk64(input string name, input int port, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h at %0t", name, port, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input int port, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %b want %b at %0t", name, port, act, exp, $time);
    end
  endtask

  // Monitor: outputs are settled mid-cycle; compare against the oldest expectation.
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      for (int i = 0; i < NRD; i++) begin
        chk64("rd_data_byp", i, rd_data_b[i*64 +: 64], e.rdb[i]);
        chk64("rd_data_nobyp", i, rd_data_n[i*64 +: 64], e.rdn[i]);
        chk1("rd_busy_byp", i, rd_busy_b[i], e.busy[i]);
        chk1("rd_busy_nobyp", i, rd_busy_n[i], e.busy[i]);
      end
      chk1("sb_full_byp", 0, sb_full_b, e.sbf);
      chk1("sb_full_nobyp", 0, sb_full_n, e.sbf);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset values, including SP
    idle(); ra[0] = 0; ra[1] = 5; ra[2] = SP; step();
    idle(); ra[0] = SP; rsp[0] = 1'b0; ra[1] = 30; step();

    // Same-address collision: port 1 wins
    idle(); wen[0] = 1; wa[0] = 5; wd[0] = 64'hAA; wen[1] = 1; wa[1] = 5; wd[1] = 64'hBB; ra[0] = 5; step();
    idle(); ra[0] = 5; step();

    // Forwarding of a fresh write
    idle(); wen[0] = 1; wa[0] = 7; wd[0] = 64'h1234; ra[1] = 7; step();
    idle(); ra[1] = 7; step();

    // XZR write discarded; SP unchanged
    idle(); wen[1] = 1; wa[1] = SP; wsp[1] = 0; wd[1] = 64'hFF;
    ra[0] = SP; rsp[0] = 0; ra[1] = SP; rsp[1] = 1; step();
    idle(); ra[0] = SP; rsp[0] = 0; ra[1] = SP; rsp[1] = 1; step();
    // SP write forwards only to SP reads
    idle(); wen[0] = 1; wa[0] = SP; wsp[0] = 1; wd[0] = 64'h77;
    ra[0] = SP; rsp[0] = 0; ra[1] = SP; rsp[1] = 1; step();
    idle(); ra[1] = SP; step();

    // Pending set/clear priority
    idle(); iss = 1; iaddr = 3; step();
    idle(); ra[0] = 3; step();
    idle(); wen[0] = 1; wa[0] = 3; wd[0] = 64'h33; iss = 1; iaddr = 3; ra[0] = 3; step();
    idle(); ra[0] = 3; step();
    idle(); wen[1] = 1; wa[1] = 3; wd[1] = 64'h34; ra[0] = 3; step();
    idle(); ra[0] = 3; step();
    // Issue to alias slot is ignored
    idle(); iss = 1; iaddr = SP; ra[0] = SP; step();

    // Fill the scoreboard, then flush together with a new issue
    for (int r = 0; r < SP; r++) begin
      idle(); iss = 1; iaddr = r; ra[0] = r; ra[2] = (r + 1) % SP; step();
    end
    idle(); ra[0] = 30; step();
    idle(); fl = 1; iss = 1; iaddr = 12; step();
    idle(); ra[0] = 12; ra[1] = 13; ra[2] = 0; step();
    idle(); fl = 1; step();

    // Reset asserted during a write: the write is lost
    idle(); wen[0] = 1; wa[0] = 9; wd[0] = 64'h9999; iss = 1; iaddr = 9;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(); ra[0] = 9; ra[1] = SP; ra[2] = 5; step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NRD; i++) begin
        ra[i]  = rand_addr();
        rsp[i] = bit'($urandom_range(0, 1));
      end
      for (int j = 0; j < NWR; j++) begin
        wen[j] = bit'($urandom_range(0, 1));
        wsp[j] = bit'($urandom_range(0, 1));
        wa[j]  = rand_addr();
        wd[j]  = {$urandom, $urandom};
      end
      iss   = ($urandom_range(0, 3) != 0);
      iaddr = rand_addr();
      fl    = ($urandom_range(0, 15) == 0);
      step();
    end

    idle();
    for (int k = 0; k < 5 && sbq.size() != 0; k++) @(posedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
